// File: rtl/cpu_io_mailbox.sv
// cpu_io_mailbox: turns the CPU's 8-bit out/in ports into host-side RX/TX byte streams
module cpu_io_mailbox #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    ExternalReset,
    input  logic [7:0]              cpu_out,
    output logic [7:0]              cpu_in,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic                    rx_overflow,
    input  logic                    ovf_clr,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] tx_count;
    logic [7:0]    prev_out;
    logic [HW-1:0] cnt;
    state_t        state;
    logic          rx_chg, rx_pop, rx_push, tx_pop, tx_push;

    // A full RX FIFO still accepts a capture when the host frees a slot on the same edge;
    // likewise the TX side accepts a push whenever the FSM is popping that edge.
    always_comb begin
        rx_valid = rx_count != '0;
        rx_data  = rx_valid ? rx_mem[rx_rp] : 8'h00;
        rx_chg   = cpu_out != prev_out;
        rx_pop   = rx_valid && rx_ready;
        rx_push  = rx_chg && (rx_count != CW'(DEPTH) || rx_pop);
        tx_pop   = tx_count != '0 && (state == IDLE || cnt == '0);
        tx_ready = tx_count != CW'(DEPTH) || tx_pop;
        tx_push  = tx_valid && tx_ready;
    end

    // RX capture: one entry per change of cpu_out, sticky flag for dropped values
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            prev_out    <= '0;
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_count    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_chg) prev_out <= cpu_out;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_count    <= rx_count + CW'(rx_push) - CW'(rx_pop);
            rx_overflow <= (rx_chg && !rx_push) || (rx_overflow && !ovf_clr);
        end
    end

    // FIFO storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= cpu_out;
        if (tx_push) tx_mem[tx_wp] <= tx_data;
    end

    // TX write side and occupancy
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            tx_wp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // TX FSM: present each byte for HOLD_CYCLES cycles, chaining bytes without gaps
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            state   <= IDLE;
            cnt     <= '0;
            cpu_in  <= '0;
            tx_busy <= 1'b0;
            tx_rp   <= '0;
        end else if (tx_pop) begin
            cpu_in  <= tx_mem[tx_rp];
            tx_rp   <= tx_rp + 1'b1;
            cnt     <= HW'(HOLD_CYCLES - 1);
            state   <= HOLD;
            tx_busy <= 1'b1;
        end else if (state == HOLD) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state   <= IDLE;
                tx_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_io_mailbox.sv
// tb_cpu_io_mailbox: directed and random stimulus against a queue-based reference model
module tb_cpu_io_mailbox;
    localparam int DEPTH = 8;
    localparam int HOLD  = 16;

    logic       clk = 1'b0;
    logic       ExternalReset = 1'b0;
    logic [7:0] cpu_out = '0, cpu_in, rx_data, tx_data = '0;
    logic       rx_valid, rx_ready = 1'b0, rx_overflow, ovf_clr = 1'b0;
    logic [3:0] rx_count;
    logic       tx_valid = 1'b0, tx_ready, tx_busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] rx_exp[$];
    logic [7:0] txq[$];
    int         m_rxn = 0;
    int         m_rem = 0;
    logic [7:0] m_prev = '0;
    logic [7:0] m_cur = '0;
    logic       m_ovf = 1'b0;

    cpu_io_mailbox #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .ExternalReset(ExternalReset), .cpu_out(cpu_out), .cpu_in(cpu_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        rx_exp.delete();
        txq.delete();
        m_rxn = 0;
        m_rem = 0;
        m_prev = '0;
        m_cur = '0;
        m_ovf = 1'b0;
    endtask

    // One clock edge of the intended behaviour, from the inputs held across that edge
    task automatic step();
        bit rpop, chg, drop, tpop, tacc;
        rpop = m_rxn > 0 && rx_ready;
        chg  = cpu_out != m_prev;
        drop = chg && m_rxn == DEPTH && !rpop;
        tpop = txq.size() > 0 && m_rem <= 1;
        tacc = tx_valid && (txq.size() < DEPTH || tpop);
        if (rpop) m_rxn--;
        if (chg) begin
            m_prev = cpu_out;
            if (!drop) begin
                m_rxn++;
                rx_exp.push_back(cpu_out);
            end
        end
        m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        if (tpop) begin
            m_cur = txq.pop_front();
            m_rem = HOLD;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (tacc) txq.push_back(tx_data);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (ExternalReset) step();
        else reset_model();
        #2;
    endtask

    task automatic assert_reset();
        ExternalReset = 1'b0;
        reset_model();
    endtask

    // monitor: compares DUT outputs with the model and drains the RX scoreboard on each pop
    always @(negedge clk) begin
        logic [7:0] e;
        check("rx_count", rx_count, m_rxn);
        check("rx_valid", rx_valid, m_rxn > 0);
        check("rx_overflow", rx_overflow, m_ovf);
        check("cpu_in", cpu_in, m_cur);
        check("tx_busy", tx_busy, m_rem > 0);
        check("tx_ready", tx_ready, txq.size() < DEPTH || (txq.size() > 0 && m_rem <= 1));
        if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_pop_unexpected: got %0h expected none", rx_data);
            end else begin
                e = rx_exp.pop_front();
                check("rx_data", rx_data, e);
            end
        end else if (!rx_valid) begin
            check("rx_data_empty", rx_data, 0);
        end
    end

    initial begin
        int na, nb;
        // T1: reset held while inputs toggle
        repeat (5) begin
            cpu_out  = 8'($urandom);
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            cyc();
        end
        check("t1_cpu_in", cpu_in, 0);
        check("t1_rx_valid", rx_valid, 0);
        check("t1_tx_ready", tx_ready, 1);
        check("t1_ovf", rx_overflow, 0);
        cpu_out = 8'h00;
        tx_valid = 1'b0;
        ExternalReset = 1'b1;
        cyc();
        // T2: steady value produces a single entry
        cpu_out = 8'h5A;
        repeat (10) cyc();
        check("t2_count", rx_count, 1);
        check("t2_data", rx_data, 8'h5A);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        repeat (3) cyc();
        check("t2_empty", rx_valid, 0);
        // T3: nine changes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            cpu_out = 8'(i);
            cyc();
        end
        check("t3_count", rx_count, 8);
        check("t3_ovf", rx_overflow, 1);
        rx_ready = 1'b1;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        repeat (7) cyc();
        rx_ready = 1'b0;
        check("t3_ovf_clr", rx_overflow, 0);
        // T4: push and pop on the same edge while full
        for (int i = 8'h11; i <= 8'h18; i++) begin
            cpu_out = 8'(i);
            cyc();
        end
        cpu_out = 8'h19;
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        check("t4_count", rx_count, 8);
        check("t4_ovf", rx_overflow, 0);
        rx_ready = 1'b1;
        repeat (9) cyc();
        rx_ready = 1'b0;
        // T5: two bytes back to back, each held HOLD cycles
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            tx_valid = i < 2;
            tx_data  = (i == 0) ? 8'hA1 : 8'hB2;
            cyc();
            if (tx_busy && cpu_in == 8'hA1) na++;
            if (tx_busy && cpu_in == 8'hB2) nb++;
        end
        check("t5_a1_cycles", na, HOLD);
        check("t5_b2_cycles", nb, HOLD);
        check("t5_busy_low", tx_busy, 0);
        check("t5_retain", cpu_in, 8'hB2);
        // T6: reset mid-HOLD with bytes still queued
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'hC1 + 8'(i);
            cyc();
        end
        tx_valid = 1'b0;
        repeat (9) cyc();
        check("t6_busy_before", tx_busy, 1);
        assert_reset();
        #1;
        check("t6_cpu_in", cpu_in, 0);
        check("t6_busy", tx_busy, 0);
        cpu_out = 8'h00;
        repeat (2) cyc();
        ExternalReset = 1'b1;
        repeat (40) cyc();
        check("t6_no_stale", cpu_in, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 30) cpu_out = 8'($urandom_range(7));
            rx_ready = $urandom_range(99) < 40;
            ovf_clr  = $urandom_range(99) < 5;
            tx_valid = $urandom_range(99) < 15;
            tx_data  = 8'($urandom);
            if ($urandom_range(999) == 0) assert_reset();
            else ExternalReset = 1'b1;
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
